out_uart: RTL and testbench
===========================

OUT_UART -- requirements
Module: out_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: clock cycles per UART bit, legal values 2..65535.
REQ-002 Parameter DEPTH, default 8: output FIFO entries, power of 2, range 2..64.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 out_data  input  8: byte driven by the CPU OUT instruction (CPU LEDS bus).
REQ-006 out_strobe  input  1: CPU OUT strobe (CPU Lr), level-held, may stay high for several cycles.
REQ-007 txd  output  1: UART transmit line, 8N1, LSB first, idle high.
REQ-008 leds  output  8: registered copy of the last captured out_data.
REQ-009 full  output  1: FIFO holds DEPTH bytes.
REQ-010 busy  output  1: TX FSM not IDLE, or FIFO not empty.
REQ-011 overflow  output  1: sticky; a byte was dropped because the FIFO was full.

Function
REQ-012 Capture SHALL occur only on a rising edge of out_strobe (sampled high, previous sample low); one byte per edge; holding the strobe high SHALL capture nothing further.
REQ-013 On capture, leds SHALL load out_data at that edge, whether or not the FIFO is full.
REQ-014 On capture with the FIFO not full, out_data SHALL be written at that edge; count SHALL be visible the next cycle.
REQ-015 On capture with the FIFO full and no pop in the same cycle, the byte SHALL be dropped and overflow set; FIFO contents SHALL be unchanged.
REQ-016 Capture and pop in the same cycle while full SHALL accept the byte; count SHALL be unchanged and overflow SHALL stay clear.
REQ-017 Pointers SHALL be log2(DEPTH)+1 bits: empty when equal, full when equal except the MSB; wrap-around SHALL be transparent.
REQ-018 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE->START when the FIFO is non-empty: pop the head byte into the shift register and drive txd low at the same edge.
REQ-020 START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded with CLKS_PER_BIT-1.
REQ-021 DATA SHALL send bit 0 first through bit 7, using a 3-bit bit index; after bit 7 go to STOP with txd high.
REQ-022 At the end of STOP, go to START with a pop if the FIFO is non-empty (no gap), else go to IDLE.
REQ-023 A full frame SHALL be 10*CLKS_PER_BIT cycles; txd SHALL be registered and glitch-free.
REQ-024 Latency: a byte captured at edge E into an empty FIFO with the FSM in IDLE SHALL pop at E+1, with txd low from E+1.

Reset
REQ-025 While rst_n is low: txd=1, leds=0, full=0, busy=0, overflow=0, pointers=0, FSM=IDLE, counters=0, strobe-history flop=1 so a strobe already high at release does not capture.
REQ-026 Reset mid-frame SHALL abort the frame immediately (txd high) and discard FIFO contents; overflow SHALL clear only on reset.

Structure
REQ-027 Shared package out_uart_pkg SHALL hold the tx_state_t enum (IDLE, START, DATA, STOP) and the CLKS_PER_BIT and DEPTH defaults.
REQ-028 The FIFO SHALL be a sub-module byte_fifo (8-bit, parameter DEPTH, push/pop/full/empty) instantiated once; edge detect and the TX FSM stay in out_uart.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-029 Single byte: rising edge with 0xA5 -> leds=0xA5; txd low at E+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy clears after 40 cycles.
REQ-030 Held strobe: strobe high 20 cycles with 0x3C -> exactly one 0x3C frame.
REQ-031 Burst: 5 bytes 0x01..0x05 each captured before any pop -> full after 4; 0x05 dropped; overflow=1; frames 0x01..0x04 back-to-back with no idle gap; leds=0x05.
REQ-032 Full plus pop: strobe edge on the same cycle the FSM pops from a full FIFO -> byte kept, overflow stays 0.
REQ-033 Reset mid-DATA on the 3rd bit -> txd=1 immediately; busy=0; later edge with 0x7E -> clean frame with 0x7E.
REQ-034 Wrap: 12 bytes sent one at a time with gaps -> all 12 received in order; pointers wrap 3 times.

Source files
------------

// File: rtl/out_uart_pkg.sv
// Shared types and defaults for the OUT-port UART bridge.
package out_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEF = 104;
  localparam int unsigned DEPTH_DEF        = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with extra-MSB pointers; head byte is read combinationally.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0] wr_q;
  logic [AW:0] wr_d;
  logic [AW:0] rd_q;
  logic [AW:0] rd_d;
  logic [7:0]  mem_q [DEPTH];

  assign wr_d = push_i ? wr_q + ONE : wr_q;
  assign rd_d = pop_i  ? rd_q + ONE : rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/out_uart.sv
// CPU OUT-port capture into a byte FIFO, drained by an 8N1 transmitter.
module out_uart
  import out_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] out_data,
  input  logic       out_strobe,
  output logic       txd,
  output logic [7:0] leds,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state_q;
  tx_state_t   state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  bit_q;
  logic [2:0]  bit_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        txd_q;
  logic        txd_d;
  logic        strobe_q;
  logic [7:0]  leds_q;
  logic        ovf_q;

  logic        capture;
  logic        push;
  logic        pop;
  logic [7:0]  head;
  logic        fifo_full;
  logic        fifo_empty;

  assign capture = out_strobe & ~strobe_q;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push    = capture & (~fifo_full | pop);

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (out_data),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b1;
      leds_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      strobe_q <= out_strobe;
      if (capture) begin
        leds_q <= out_data;
      end
      if (capture && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          cnt_d   = RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          cnt_d   = RELOAD;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          cnt_d   = RELOAD;
          state_d = START;
        end else begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign txd      = txd_q;
  assign leds     = leds_q;
  assign full     = fifo_full;
  assign busy     = (state_q != IDLE) | ~fifo_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_out_uart.sv
// Bench for out_uart: serial receiver monitor plus per-scenario tasks.
module tb_out_uart;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] out_data;
  logic       out_strobe;
  logic       txd;
  logic [7:0] leds;
  logic       full;
  logic       busy;
  logic       overflow;

  int checks;
  int passes;
  int cyc;

  logic [7:0] rx_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];

  out_uart #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .txd        (txd),
    .leds       (leds),
    .full       (full),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver: sample mid-slot on falling edges, 10 slots per frame.
  initial begin
    bit         mon_busy;
    int         mon_t;
    int         s;
    logic [7:0] mon_b;
    mon_busy = 1'b0;
    mon_t    = 0;
    mon_b    = '0;
    cyc      = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (txd === 1'b0) begin
          mon_busy = 1'b1;
          mon_t    = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_t++;
        if ((mon_t - (CPB/2 - 1)) % CPB == 0) begin
          s = (mon_t - (CPB/2 - 1)) / CPB;
          if (s == 0) begin
            checks++;
            if (txd !== 1'b0) $display("FAIL mon_start got %b want 0", txd);
            else passes++;
          end else if (s >= 1 && s <= 8) begin
            mon_b[3'(s-1)] = txd;
          end else if (s == 9) begin
            checks++;
            if (txd !== 1'b1) $display("FAIL mon_stop got %b want 1", txd);
            else passes++;
            rx_q.push_back(mon_b);
          end
        end
        if (mon_t == 10*CPB - 1) mon_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b);
    out_data   = b;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    out_strobe = 1'b1;
    out_data   = 8'($urandom_range(1, 255));
    repeat (3) tick();
    checks++;
    if ({txd, leds, full, busy, overflow} !== {1'b1, 8'h00, 3'b000}) begin
      $display("FAIL reset_vals got txd=%b leds=%h full=%b busy=%b ovf=%b want 1/00/0/0/0",
               txd, leds, full, busy, overflow);
    end else passes++;
    rst_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || leds !== 8'h00) begin
      $display("FAIL reset_held_strobe got busy=%b leds=%h want 0/00", busy, leds);
    end else passes++;
    out_strobe = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [9:0] frame;
    bit ok;
    rx_q.delete();
    frame = {1'b1, b, 1'b0};
    out_data   = b;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    checks++;
    if (leds !== b || txd !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL single_capture got leds=%h txd=%b busy=%b want %h/1/1", leds, txd, busy, b);
    end else passes++;
    tick();
    for (int s = 0; s < 10; s++) begin
      checks++;
      if (txd !== frame[s]) $display("FAIL single_slot%0d got %b want %b", s, txd, frame[s]);
      else passes++;
      repeat ((s < 9) ? CPB : CPB - 1) tick();
    end
    checks++;
    if (busy !== 1'b1) $display("FAIL single_busy_end got %b want 1", busy);
    else passes++;
    tick();
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      $display("FAIL single_idle got busy=%b txd=%b want 0/1", busy, txd);
    end else passes++;
    wait_idle(20, ok);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      $display("FAIL single_rx got n=%0d first=%h want 1/%h", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
    end else passes++;
  endtask

  task automatic test_held();
    bit ok;
    rx_q.delete();
    out_data   = 8'h3C;
    out_strobe = 1'b1;
    repeat (20) tick();
    out_strobe = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (!ok) $display("FAIL held_timeout got busy=%b want 0", busy);
    else passes++;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      $display("FAIL held_rx got n=%0d want 1 frame of 3c", rx_q.size());
    end else passes++;
  endtask

  task automatic test_burst();
    bit ok;
    rx_q.delete();
    start_q.delete();
    exp_q = '{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    pulse(8'hFF);
    for (int k = 1; k <= 5; k++) begin
      out_data   = 8'(k);
      out_strobe = 1'b1;
      tick();
      out_strobe = 1'b0;
      if (k == 4) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          $display("FAIL burst_full got full=%b ovf=%b want 1/0", full, overflow);
        end else passes++;
      end
      tick();
    end
    checks++;
    if (overflow !== 1'b1 || leds !== 8'h05 || full !== 1'b1) begin
      $display("FAIL burst_drop got ovf=%b leds=%h full=%b want 1/05/1", overflow, leds, full);
    end else passes++;
    wait_idle(400, ok);
    checks++;
    if (!ok) $display("FAIL burst_timeout got busy=%b want 0", busy);
    else passes++;
    checks++;
    if (rx_q != exp_q) begin
      $display("FAIL burst_rx got n=%0d %p want %p", rx_q.size(), rx_q, exp_q);
    end else passes++;
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] != 10*CPB) begin
        $display("FAIL burst_gap%0d got %0d want %0d", i, start_q[i] - start_q[i-1], 10*CPB);
      end else passes++;
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    logic [7:0] b;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    exp_q.delete();
    b = 8'($urandom);
    exp_q.push_back(b);
    out_data   = b;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    tick();
    for (int k = 0; k < DEP; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      pulse(b);
    end
    checks++;
    if (full !== 1'b1) $display("FAIL fullpop_prefill got full=%b want 1", full);
    else passes++;
    // first pop happened one edge after the first capture; the next is 40 later
    repeat (10*CPB - 2*DEP - 1) tick();
    b = 8'($urandom);
    exp_q.push_back(b);
    out_data   = b;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1 || txd !== 1'b0) begin
      $display("FAIL fullpop_same got ovf=%b full=%b txd=%b want 0/1/0", overflow, full, txd);
    end else passes++;
    wait_idle(600, ok);
    checks++;
    if (!ok || rx_q != exp_q) begin
      $display("FAIL fullpop_rx got n=%0d %p want %p", rx_q.size(), rx_q, exp_q);
    end else passes++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    rx_q.delete();
    out_data   = 8'($urandom);
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    tick();
    pulse(8'($urandom));
    repeat (CPB*3 - 1) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      $display("FAIL midrst_abort got txd=%b busy=%b full=%b want 1/0/0", txd, busy, full);
    end else passes++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (rx_q.size() != 0 || busy !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL midrst_flush got n=%0d busy=%b ovf=%b want 0/0/0", rx_q.size(), busy, overflow);
    end else passes++;
    pulse(8'h7E);
    wait_idle(100, ok);
    checks++;
    if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h7E) begin
      $display("FAIL midrst_rx got n=%0d want 1 frame of 7e", rx_q.size());
    end else passes++;
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok;
    logic [7:0] b;
    rx_q.delete();
    exp_q.delete();
    all_ok = 1'b1;
    for (int k = 0; k < 3*DEP; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      pulse(b);
      wait_idle(100, ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || rx_q != exp_q) begin
      $display("FAIL wrap_rx got n=%0d %p want %p", rx_q.size(), rx_q, exp_q);
    end else passes++;
    checks++;
    if (leds !== exp_q[exp_q.size()-1] || overflow !== 1'b0) begin
      $display("FAIL wrap_leds got leds=%h ovf=%b want %h/0", leds, overflow, exp_q[exp_q.size()-1]);
    end else passes++;
  endtask

  initial begin
    checks     = 0;
    passes     = 0;
    rst_n      = 1'b0;
    out_strobe = 1'b0;
    out_data   = '0;
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_held();
    test_burst();
    test_full_pop();
    test_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
